// File: rtl/shift_issue_if.sv
// Shift-issue handshake bundle: upstream instruction side plus
// downstream shifter operand side, valid/ready on each.
interface shift_issue_if;
  logic        In_Valid;
  logic        In_Ready;
  logic [5:0]  Func;
  logic [4:0]  Shamt;
  logic [31:0] Rs;
  logic [31:0] Rt;
  logic [4:0]  Rd;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [31:0] X;
  logic [4:0]  Sa;
  logic        Arith;
  logic        Right;
  logic [4:0]  Out_Rd;
  logic        Illegal;

  modport master (
    output In_Valid, Func, Shamt, Rs, Rt, Rd, Out_Ready,
    input  In_Ready, Out_Valid, X, Sa, Arith, Right, Out_Rd, Illegal
  );

  modport slave (
    input  In_Valid, Func, Shamt, Rs, Rt, Rd, Out_Ready,
    output In_Ready, Out_Valid, X, Sa, Arith, Right, Out_Rd, Illegal
  );
endinterface

// File: rtl/shift_issue.sv
// Shift instruction decode and 2-entry issue FIFO.
// Head entry drives the shifter operands directly from flops.
module shift_issue (
  input  logic          Clk,
  input  logic          Clrn,
  shift_issue_if.slave  bus
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  typedef struct packed {
    logic [31:0] x;
    logic [4:0]  sa;
    logic        arith;
    logic        right;
    logic [4:0]  rd;
  } ent_t;

  logic [1:0] state;
  ent_t       head;
  ent_t       tail;
  ent_t       nent;
  logic       legal;
  logic       vsel;
  logic       illq;
  logic       in_fire;
  logic       push;
  logic       pop;

  assign bus.In_Ready  = (state != TWO);
  assign bus.Out_Valid = (state != EMPTY);
  assign bus.X         = head.x;
  assign bus.Sa        = head.sa;
  assign bus.Arith     = head.arith;
  assign bus.Right     = head.right;
  assign bus.Out_Rd    = head.rd;
  assign bus.Illegal   = illq;

  assign in_fire = bus.In_Valid & bus.In_Ready;
  assign push    = in_fire & legal;
  assign pop     = bus.Out_Valid & bus.Out_Ready;

  // Decode funct into direction, sign fill and amount source
  always_comb begin
    legal      = 1'b1;
    vsel       = 1'b0;
    nent.x     = bus.Rt;
    nent.rd    = bus.Rd;
    nent.arith = 1'b0;
    nent.right = 1'b0;
    unique case (1'b1)
      (bus.Func == 6'b000000): begin
      end
      (bus.Func == 6'b000010): begin
        nent.right = 1'b1;
      end
      (bus.Func == 6'b000011): begin
        nent.right = 1'b1;
        nent.arith = 1'b1;
      end
      (bus.Func == 6'b000100): begin
        vsel = 1'b1;
      end
      (bus.Func == 6'b000110): begin
        vsel       = 1'b1;
        nent.right = 1'b1;
      end
      (bus.Func == 6'b000111): begin
        vsel       = 1'b1;
        nent.right = 1'b1;
        nent.arith = 1'b1;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
    nent.sa = vsel ? bus.Rs[4:0] : bus.Shamt;
  end

  // FIFO occupancy and entry movement
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head  <= nent;
            state <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head <= nent;
          end else if (push) begin
            tail  <= nent;
            state <= TWO;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head  <= tail;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // One-cycle flag for an accepted non-shift funct
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) illq <= 1'b0;
    else       illq <= in_fire & ~legal;
  end

endmodule
